// File: rtl/pixel_palette_mapper.sv
// pixel_palette_mapper
//   Colour stage between the VGA timing generator and the output pins. For every
//   active pixel it reads an IDX_W-bit class index from frame-buffer BRAM and maps
//   it to COLOR_W-bit rgb. The mapping uses either the active palette or a
//   grayscale ramp of the index. Sync and blank are delayed so that they stay
//   aligned with rgb.
//   A new palette or mode is accepted into a single pending slot through a
//   valid/ready handshake. It is copied into the active set only on the frame
//   boundary, so a frame never mixes two palettes.
//
// Ports
//   clock, reset_n             pixel clock, synchronous active-low reset
//   hcount, vcount             current pixel position from the timing generator
//   hsync_in, vsync_in         syncs aligned with hcount
//   blank_in                   1 = outside active video
//   palette_in                 entry k (1..2**IDX_W-1) at bits [k*COLOR_W-1 -: COLOR_W]
//   mode_in                    0 = palette, 1 = grayscale of index
//   palette_valid              producer offers palette_in/mode_in
//   palette_ready              pending slot is empty
//   mem_addr, mem_data         frame-buffer read port (data RD_LATENCY cycles later)
//   rgb                        pixel colour, RD_LATENCY+2 cycles after the hcount sample
//   hsync_out, vsync_out       delayed syncs, aligned with rgb
//   blank_out                  delayed blank, aligned with rgb
module pixel_palette_mapper #(
  parameter int H_ACTIVE   = 640,
  parameter int V_ACTIVE   = 480,
  parameter int CNT_W      = 11,
  parameter int ADDR_W     = 19,
  parameter int IDX_W      = 3,
  parameter int COLOR_W    = 12,
  parameter int RD_LATENCY = 2
) (
  input  logic                                 clock,
  input  logic                                 reset_n,
  input  logic [CNT_W-1:0]                     hcount,
  input  logic [CNT_W-1:0]                     vcount,
  input  logic                                 hsync_in,
  input  logic                                 vsync_in,
  input  logic                                 blank_in,
  input  logic [((2**IDX_W)-1)*COLOR_W-1:0]    palette_in,
  input  logic                                 mode_in,
  input  logic                                 palette_valid,
  output logic                                 palette_ready,
  output logic [ADDR_W-1:0]                    mem_addr,
  input  logic [IDX_W-1:0]                     mem_data,
  output logic [COLOR_W-1:0]                   rgb,
  output logic                                 hsync_out,
  output logic                                 vsync_out,
  output logic                                 blank_out
);

  localparam int L      = RD_LATENCY + 2;
  localparam int N_ENT  = (2**IDX_W) - 1;
  localparam int PAL_W  = N_ENT * COLOR_W;
  localparam int COMP_W = COLOR_W / 3;
  // Enough index copies to cover one colour component; the MSBs are kept.
  localparam int REP    = COMP_W / IDX_W + 1;

  localparam logic [CNT_W-1:0] H_ACT_C = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT_C = CNT_W'(V_ACTIVE);

  logic [ADDR_W-1:0]      pix_cnt;
  logic [L-1:0]           hs_sr;
  logic [L-1:0]           vs_sr;
  logic [L-1:0]           bl_sr;
  logic [PAL_W-1:0]       palette_active;
  logic [PAL_W-1:0]       palette_pending;
  logic                   mode_active;
  logic                   mode_pending;
  logic                   slot_empty;

  logic                   frame_start;
  logic                   active_px;
  logic [COLOR_W-1:0]     pal_col;
  logic [COLOR_W-1:0]     gray_col;
  logic [REP*IDX_W-1:0]   rep_idx;
  logic [COMP_W-1:0]      gray_comp;

  assign frame_start = (hcount == '0) && (vcount == V_ACT_C);
  assign active_px   = (hcount < H_ACT_C) && (vcount < V_ACT_C);

  always_comb begin
    pal_col = '0;
    for (int k = 1; k <= N_ENT; k++) begin
      if (mem_data == IDX_W'(k)) pal_col = palette_active[(k-1)*COLOR_W +: COLOR_W];
    end
  end

  always_comb begin
    rep_idx   = {REP{mem_data}};
    gray_comp = rep_idx[REP*IDX_W-1 -: COMP_W];
    gray_col  = '0;
    gray_col[3*COMP_W-1:0] = {3{gray_comp}};
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      pix_cnt         <= '0;
      mem_addr        <= '0;
      hs_sr           <= '0;
      vs_sr           <= '0;
      bl_sr           <= '1;
      rgb             <= '0;
      palette_active  <= '0;
      palette_pending <= '0;
      mode_active     <= 1'b0;
      mode_pending    <= 1'b0;
      slot_empty      <= 1'b1;
    end else begin
      // Raster address as a running count: rewound in vertical blank,
      // frozen in horizontal blank.
      if (vcount >= V_ACT_C) begin
        pix_cnt <= '0;
      end else if (active_px) begin
        mem_addr <= pix_cnt;
        pix_cnt  <= pix_cnt + ADDR_W'(1);
      end

      hs_sr <= {hs_sr[L-2:0], hsync_in};
      vs_sr <= {vs_sr[L-2:0], vsync_in};
      bl_sr <= {bl_sr[L-2:0], blank_in};

      // bl_sr[L-2] is this pixel's blank one stage before it lands in blank_out.
      if (bl_sr[L-2])        rgb <= '0;
      else if (mode_active)  rgb <= gray_col;
      else                   rgb <= pal_col;

      // The boundary swap takes priority. An offer that lands on the boundary
      // cycle with the slot empty fills the slot and waits for the next boundary.
      if (frame_start && !slot_empty) begin
        palette_active <= palette_pending;
        mode_active    <= mode_pending;
        slot_empty     <= 1'b1;
      end else if (palette_valid && slot_empty) begin
        palette_pending <= palette_in;
        mode_pending    <= mode_in;
        slot_empty      <= 1'b0;
      end
    end
  end

  assign palette_ready = slot_empty;
  assign hsync_out     = hs_sr[L-1];
  assign vsync_out     = vs_sr[L-1];
  assign blank_out     = bl_sr[L-1];

endmodule

// File: tb/tb_pixel_palette_mapper.sv
// Bench for pixel_palette_mapper: 640-wide lines with a shortened frame height
// so that several frames fit in the run. BRAM model has latency 2 and returns addr[2:0].
module tb_pixel_palette_mapper;

  localparam int HA    = 640;
  localparam int VA    = 8;
  localparam int H_TOT = 656;
  localparam int V_TOT = 10;
  localparam int LIMIT = 10000;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [10:0]   hcount, vcount;
  logic          hsync_in, vsync_in, blank_in;
  logic [83:0]   palette_in;
  logic          mode_in, palette_valid, palette_ready;
  logic [18:0]   mem_addr;
  logic [2:0]    mem_data = '0;
  logic [2:0]    bram_d1 = '0;
  logic [11:0]   rgb;
  logic          hsync_out, vsync_out, blank_out;

  int h, v;
  int tests = 0;
  int failed = 0;

  pixel_palette_mapper #(
    .H_ACTIVE(HA), .V_ACTIVE(VA), .CNT_W(11), .ADDR_W(19),
    .IDX_W(3), .COLOR_W(12), .RD_LATENCY(2)
  ) dut (
    .clock(clk), .reset_n(reset_n), .hcount(hcount), .vcount(vcount),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .blank_in(blank_in),
    .palette_in(palette_in), .mode_in(mode_in), .palette_valid(palette_valid),
    .palette_ready(palette_ready), .mem_addr(mem_addr), .mem_data(mem_data),
    .rgb(rgb), .hsync_out(hsync_out), .vsync_out(vsync_out), .blank_out(blank_out)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    bram_d1  <= mem_addr[2:0];
    mem_data <= bram_d1;
  end

  typedef struct {
    int   h;
    int   v;
    int   addr;
    int   col;
    bit   bl;
    bit   hs;
    bit   vs;
  } probe_t;

  probe_t tbl[10];

  function automatic logic [83:0] make_pal(input logic [11:0] base, input logic [11:0] step);
    logic [83:0] p;
    p = '0;
    for (int k = 1; k <= 7; k++) p[(k-1)*12 +: 12] = base + step * 12'(k);
    return p;
  endfunction

  task automatic set_inputs();
    hcount   = 11'(h);
    vcount   = 11'(v);
    blank_in = !(h < HA && v < VA);
    hsync_in = (h >= HA + 2 && h < HA + 10);
    vsync_in = (v == VA + 1);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    h++;
    if (h == H_TOT) begin
      h = 0;
      v++;
      if (v == V_TOT) v = 0;
    end
    set_inputs();
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic seek(input int ph, input int pv);
    int n;
    n = 0;
    while (!(h == ph && v == pv) && n < LIMIT) begin
      tick();
      n++;
    end
    tests++;
    if (n >= LIMIT) begin
      failed++;
      $display("FAIL seek(%0d,%0d): timed out, got no position match, expected match", ph, pv);
    end
  endtask

  // Present (ph,pv), check mem_addr one edge later, then the colour and syncs
  // L=4 edges after the sample.
  task automatic probe(input int ph, input int pv, input int ea, input int ec,
                       input bit eb, input bit ehs, input bit evs);
    seek(ph, pv);
    tick();
    check($sformatf("(%0d,%0d) mem_addr", ph, pv), 32'(mem_addr), 32'(ea));
    tick(); tick(); tick();
    check($sformatf("(%0d,%0d) rgb", ph, pv), 32'(rgb), 32'(ec));
    check($sformatf("(%0d,%0d) blank_out", ph, pv), 32'(blank_out), 32'(eb));
    check($sformatf("(%0d,%0d) hsync_out", ph, pv), 32'(hsync_out), 32'(ehs));
    check($sformatf("(%0d,%0d) vsync_out", ph, pv), 32'(vsync_out), 32'(evs));
  endtask

  initial begin
    // Palette A: entry k = 0x111*k.
    tbl[0] = '{0,   0, 0,    12'h000, 0, 0, 0};
    tbl[1] = '{5,   2, 1285, 12'h555, 0, 0, 0};
    tbl[2] = '{15,  2, 1295, 12'h777, 0, 0, 0};
    tbl[3] = '{1,   3, 1921, 12'h111, 0, 0, 0};
    tbl[4] = '{650, 3, 2559, 12'h000, 1, 0, 0};
    tbl[5] = '{639, 7, 5119, 12'h777, 0, 0, 0};
    tbl[6] = '{645, 7, 5119, 12'h000, 1, 1, 0};
    tbl[7] = '{3,   9, 5119, 12'h000, 1, 0, 1};
    tbl[8] = '{0,   0, 0,    12'h000, 0, 0, 0};
    tbl[9] = '{4,   0, 4,    12'h444, 0, 0, 0};

    reset_n = 1'b0;
    palette_valid = 1'b0;
    palette_in = '0;
    mode_in = 1'b0;
    h = 100;
    v = 3;
    set_inputs();

    // Reset held mid-line.
    repeat (4) tick();
    check("reset rgb", 32'(rgb), 32'h0);
    check("reset blank_out", 32'(blank_out), 32'h1);
    check("reset hsync_out", 32'(hsync_out), 32'h0);
    check("reset palette_ready", 32'(palette_ready), 32'h1);
    check("reset mem_addr", 32'(mem_addr), 32'h0);
    reset_n = 1'b1;

    // Load palette A; until the boundary the active palette is still all zero.
    palette_valid = 1'b1;
    palette_in = make_pal(12'h000, 12'h111);
    tick();
    check("A accept ready", 32'(palette_ready), 32'h0);
    palette_valid = 1'b0;
    seek(201, 3);
    tick(); tick(); tick(); tick();
    check("zero palette rgb", 32'(rgb), 32'h0);
    check("zero palette blank_out", 32'(blank_out), 32'h0);
    seek(0, VA);
    tick();
    check("A boundary ready", 32'(palette_ready), 32'h1);

    // Addressing, latency and sync alignment.
    for (int i = 0; i < 10; i++)
      probe(tbl[i].h, tbl[i].v, tbl[i].addr, tbl[i].col, tbl[i].bl, tbl[i].hs, tbl[i].vs);

    // Handshake: B accepted mid-frame, C stalls, B then C applied at boundaries.
    seek(100, 4);
    palette_valid = 1'b1;
    palette_in = make_pal(12'hF00, 12'h001);
    tick();
    check("B accept ready", 32'(palette_ready), 32'h0);
    palette_in = make_pal(12'h0C0, 12'h001);
    repeat (20) tick();
    check("C stall ready", 32'(palette_ready), 32'h0);
    seek(0, VA);
    tick();
    check("B boundary ready", 32'(palette_ready), 32'h1);
    tick();
    check("C accept ready", 32'(palette_ready), 32'h0);
    palette_valid = 1'b0;
    probe(1, 0, 1, 12'hF01, 0, 0, 0);
    probe(6, 0, 6, 12'hF06, 0, 0, 0);
    probe(2, 0, 2, 12'h0C2, 0, 0, 0);

    // Offer accepted on the boundary cycle itself waits a full frame.
    seek(H_TOT - 1, VA - 1);
    tick();
    palette_valid = 1'b1;
    palette_in = make_pal(12'h0D0, 12'h001);
    tick();
    check("race accept ready", 32'(palette_ready), 32'h0);
    palette_valid = 1'b0;
    probe(2, 0, 2, 12'h0C2, 0, 0, 0);
    seek(0, VA);
    tick();
    check("race boundary ready", 32'(palette_ready), 32'h1);
    probe(3, 0, 3, 12'h0D3, 0, 0, 0);

    // Grayscale mode.
    palette_valid = 1'b1;
    mode_in = 1'b1;
    palette_in = make_pal(12'h000, 12'h111);
    tick();
    check("gray accept ready", 32'(palette_ready), 32'h0);
    palette_valid = 1'b0;
    mode_in = 1'b0;
    probe(7, 0, 7, 12'hFFF, 0, 0, 0);
    probe(12, 0, 12, 12'h999, 0, 0, 0);
    probe(16, 0, 16, 12'h000, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
